// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue stage: optype codes, FSM states, queue entry layout.
// The optional decoder bypass is enabled with the IQ_BYPASS_EN macro (see issue_ctrl.sv).
package issue_ctrl_pkg;

  localparam int IQ_DEPTH_DEF = 8;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_CAL  = 4'd1;
  localparam logic [3:0] OP_CALI = 4'd2;
  localparam logic [3:0] OP_STR  = 4'd3;
  localparam logic [3:0] OP_LAD  = 4'd4;
  localparam logic [3:0] OP_BRA  = 4'd5;
  localparam logic [3:0] OP_JUM  = 4'd6;

  typedef enum logic [1:0] {
    IQ_RUN   = 2'd0,
    IQ_STALL = 2'd1,
    IQ_FLUSH = 2'd2
  } iq_state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } iq_entry_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_CAL) || (op == OP_CALI) || (op == OP_STR) ||
           (op == OP_LAD) || (op == OP_BRA)  || (op == OP_JUM);
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op == OP_LAD) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/issue_ctrl_inst_queue_fifo.sv
// Circular in-order instruction queue holding {ins,pc}; push/pop/clear are pre-gated by issue_ctrl.
module inst_queue_fifo
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEF,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  iq_entry_t   wr_entry,
  output iq_entry_t   head_entry,
  output logic [AW:0] count
);

  iq_entry_t     mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  // Pointers are exactly AW bits wide, so the power-of-two depth wraps them for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wr_entry;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/issue_ctrl.sv
// Issue stage sequencer: queue head to decoder, one dispatch per cycle to ROB plus RS or LSB.
// Define IQ_BYPASS_EN to let an empty queue feed the decoder straight from fetch.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEF,
  parameter int IQ_AW    = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clr_in,
  input  logic             fet_vld_in,
  input  logic [31:0]      fet_ins_in,
  input  logic [31:0]      fet_pc_in,
  output logic             fet_rdy_out,
  output logic             dec_flg_out,
  output logic [31:0]      dec_ins_out,
  output logic [31:0]      dec_pc_out,
  input  logic [3:0]       dec_optype_in,
  input  logic             rob_full_in,
  input  logic             rs_full_in,
  input  logic             lsb_full_in,
  output logic             iss_rob_out,
  output logic             iss_rs_out,
  output logic             iss_lsb_out,
  output logic             ill_out,
  output logic [IQ_AW:0]   iq_cnt_out
);

  localparam logic [IQ_AW:0] DEPTH_CNT = (IQ_AW + 1)'(IQ_DEPTH);

  iq_state_t      state;
  iq_entry_t      head_entry;
  iq_entry_t      wr_entry;
  logic [IQ_AW:0] count;
  logic           clear;
  logic           push_ok;
  logic           head_vld;
  logic           bypass;
  logic           can_go;
  logic           legal;
  logic           is_mem;
  logic           target_ok;
  logic           disp;
  logic           ill;
  logic           consume;
  logic           fifo_push;
  logic           fifo_pop;
  logic           blocked;

  always_comb begin
    clear       = rdy_in & clr_in;
    fet_rdy_out = rdy_in & (count < DEPTH_CNT) & (state != IQ_FLUSH) & ~clr_in;
    push_ok     = fet_vld_in & fet_rdy_out;
    head_vld    = (count != '0);
`ifdef IQ_BYPASS_EN
    bypass      = ~head_vld & push_ok;
`else
    bypass      = 1'b0;
`endif
    wr_entry    = '{ins: fet_ins_in, pc: fet_pc_in};
    dec_flg_out = head_vld | bypass;
    dec_ins_out = bypass ? fet_ins_in : (head_vld ? head_entry.ins : 32'd0);
    dec_pc_out  = bypass ? fet_pc_in  : (head_vld ? head_entry.pc  : 32'd0);

    can_go    = rdy_in & ~clr_in & (state != IQ_FLUSH) & dec_flg_out;
    legal     = op_legal(dec_optype_in);
    is_mem    = op_is_mem(dec_optype_in);
    target_ok = is_mem ? ~lsb_full_in : ~rs_full_in;
    disp      = can_go & legal & ~rob_full_in & target_ok;
    // Illegal words still wait on ROB space but never on the RS/LSB target.
    ill       = can_go & ~legal & ~rob_full_in;

    iss_rob_out = disp;
    iss_lsb_out = disp & is_mem;
    iss_rs_out  = disp & ~is_mem;
    ill_out     = ill;

    consume   = disp | ill;
    fifo_push = push_ok & ~(bypass & consume);
    fifo_pop  = consume & head_vld;
    blocked   = can_go & ~consume;
    iq_cnt_out = count;
  end

  inst_queue_fifo #(
    .DEPTH (IQ_DEPTH),
    .AW    (IQ_AW)
  ) u_fifo (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .clear      (clear),
    .wr_entry   (wr_entry),
    .head_entry (head_entry),
    .count      (count)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IQ_RUN;
    end else if (rdy_in) begin
      if (clr_in) begin
        state <= IQ_FLUSH;
      end else begin
        case (state)
          IQ_RUN:   if (blocked) state <= IQ_STALL;
          IQ_STALL: if (consume || !dec_flg_out) state <= IQ_RUN;
          IQ_FLUSH: state <= IQ_RUN;
          default:  state <= IQ_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: queue-based reference model checked every cycle at negedge.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, clr_in, fet_vld_in;
  logic [31:0] fet_ins_in, fet_pc_in;
  logic        fet_rdy_out, dec_flg_out;
  logic [31:0] dec_ins_out, dec_pc_out;
  logic [3:0]  dec_optype_in;
  logic        rob_full_in, rs_full_in, lsb_full_in;
  logic        iss_rob_out, iss_rs_out, iss_lsb_out, ill_out;
  logic [3:0]  iq_cnt_out;

  int errors = 0;
  int checks = 0;

  iq_entry_t sb[$];
  bit        model_flush = 1'b0;

  always #5 clk_in = ~clk_in;

  issue_ctrl dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .clr_in        (clr_in),
    .fet_vld_in    (fet_vld_in),
    .fet_ins_in    (fet_ins_in),
    .fet_pc_in     (fet_pc_in),
    .fet_rdy_out   (fet_rdy_out),
    .dec_flg_out   (dec_flg_out),
    .dec_ins_out   (dec_ins_out),
    .dec_pc_out    (dec_pc_out),
    .dec_optype_in (dec_optype_in),
    .rob_full_in   (rob_full_in),
    .rs_full_in    (rs_full_in),
    .lsb_full_in   (lsb_full_in),
    .iss_rob_out   (iss_rob_out),
    .iss_rs_out    (iss_rs_out),
    .iss_lsb_out   (iss_lsb_out),
    .ill_out       (ill_out),
    .iq_cnt_out    (iq_cnt_out)
  );

  // Stand-in for the combinational decoder: RV32I major opcode to optype.
  function automatic logic [3:0] decode(input logic [31:0] w);
    case (w[6:0])
      7'b0110011:            return OP_CAL;
      7'b0010011:            return OP_CALI;
      7'b0100011:            return OP_STR;
      7'b0000011:            return OP_LAD;
      7'b1100011:            return OP_BRA;
      7'b1101111, 7'b1100111: return OP_JUM;
      default:               return OP_NONE;
    endcase
  endfunction

  assign dec_optype_in = decode(dec_ins_out);

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Monitor: predicts this cycle's outputs from the queue model, compares, then advances the model.
  always @(negedge clk_in) begin : monitor
    logic      exp_rdy, accepted, have_head, go, legal_w, mem_w, exp_disp, exp_ill, consumed;
    iq_entry_t head;
    logic [3:0] op;
    if (!rst_n_in) begin
      sb.delete();
      model_flush = 1'b0;
      check_output("rst_fet_rdy", 32'(fet_rdy_out), 32'(rdy_in & ~clr_in));
      check_output("rst_cnt", 32'(iq_cnt_out), 32'd0);
      check_output("rst_outs", {26'd0, dec_flg_out, iss_rob_out, iss_rs_out, iss_lsb_out, ill_out, |dec_ins_out}, 32'd0);
    end else begin
      exp_rdy   = rdy_in & (sb.size() < DEPTH) & ~model_flush & ~clr_in;
      accepted  = fet_vld_in & exp_rdy;
      have_head = (sb.size() > 0) || (BYP && accepted);
      head      = (sb.size() > 0) ? sb[0] : '{ins: fet_ins_in, pc: fet_pc_in};
      go        = rdy_in & ~clr_in & ~model_flush & have_head;
      op        = decode(head.ins);
      legal_w   = (op != OP_NONE);
      mem_w     = (op == OP_LAD) || (op == OP_STR);
      exp_disp  = go & legal_w & ~rob_full_in & (mem_w ? ~lsb_full_in : ~rs_full_in);
      exp_ill   = go & ~legal_w & ~rob_full_in;

      check_output("fet_rdy", 32'(fet_rdy_out), 32'(exp_rdy));
      check_output("count", 32'(iq_cnt_out), 32'(sb.size()));
      check_output("dec_flg", 32'(dec_flg_out), 32'(have_head));
      check_output("dec_ins", dec_ins_out, have_head ? head.ins : 32'd0);
      check_output("dec_pc", dec_pc_out, have_head ? head.pc : 32'd0);
      check_output("iss_rob", 32'(iss_rob_out), 32'(exp_disp));
      check_output("iss_rs", 32'(iss_rs_out), 32'(exp_disp & ~mem_w));
      check_output("iss_lsb", 32'(iss_lsb_out), 32'(exp_disp & mem_w));
      check_output("ill", 32'(ill_out), 32'(exp_ill));

      consumed = exp_disp | exp_ill;
      if (rdy_in && clr_in) begin
        sb.delete();
        model_flush = 1'b1;
      end else if (rdy_in) begin
        model_flush = 1'b0;
        if (consumed && sb.size() > 0) begin
          void'(sb.pop_front());
          if (accepted) sb.push_back('{ins: fet_ins_in, pc: fet_pc_in});
        end else if (accepted && !(consumed && sb.size() == 0)) begin
          sb.push_back('{ins: fet_ins_in, pc: fet_pc_in});
        end
      end
    end
  end

  task automatic apply_stimulus(input logic vld, input logic [31:0] ins, input logic [31:0] pc,
                                input logic rdy, input logic clr,
                                input logic robf, input logic rsf, input logic lsbf);
    fet_vld_in  = vld;
    fet_ins_in  = ins;
    fet_pc_in   = pc;
    rdy_in      = rdy;
    clr_in      = clr;
    rob_full_in = robf;
    rs_full_in  = rsf;
    lsb_full_in = lsbf;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0] ops [9];
    ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b1111111, 7'b0000000};
    return {$urandom() >> 7, ops[$urandom_range(8, 0)]};
  endfunction

  initial begin
    rst_n_in = 1'b0;
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    rst_n_in = 1'b1;
    idle(1);

    $display("[TB] ADDI dispatch to RS");
    apply_stimulus(1, 32'h0010_0093, 32'h0, 1, 0, 0, 0, 0);
    idle(2);

    $display("[TB] LW stalled on LSB full");
    apply_stimulus(1, 32'h0000_A103, 32'h4, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 1);
    idle(2);

    $display("[TB] fill queue under ROB full, then drain");
    for (int i = 0; i < 9; i++) apply_stimulus(1, 32'h0000_0033 | (i << 7), 32'h100 + i * 4, 1, 0, 1, 0, 0);
    idle(10);

    $display("[TB] flush with five queued and a push offered");
    for (int i = 0; i < 5; i++) apply_stimulus(1, 32'h0000_0013 | (i << 7), 32'h200 + i * 4, 1, 0, 1, 0, 0);
    apply_stimulus(1, 32'h0000_0063, 32'h300, 1, 1, 1, 0, 0);
    apply_stimulus(1, 32'h0000_0063, 32'h304, 1, 0, 1, 0, 0);
    apply_stimulus(1, 32'h0000_0063, 32'h308, 1, 0, 0, 0, 0);
    idle(3);

    $display("[TB] illegal word dropped");
    apply_stimulus(1, 32'hFFFF_FFFF, 32'h400, 1, 0, 0, 0, 0);
    idle(3);

    $display("[TB] rdy low freezes the queue");
    apply_stimulus(1, 32'h0000_2023, 32'h500, 1, 0, 0, 0, 0);
    apply_stimulus(1, 32'h0000_2003, 32'h504, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0);
    idle(3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      bit heavy;
      heavy = ((i / 60) % 2) == 1;
      if (i % 400 == 399) rst_n_in = 1'b0;
      else rst_n_in = 1'b1;
      apply_stimulus(($urandom % 4) != 0, rand_ins(), $urandom & 32'hFFFF_FFFC,
                     ($urandom % 10) != 0, ($urandom % 50) == 0,
                     heavy ? (($urandom % 3) != 0) : (($urandom % 8) == 0),
                     ($urandom % 5) == 0, ($urandom % 5) == 0);
    end
    rst_n_in = 1'b1;
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
